octave_selector: RTL
====================

// Module: octave_selector
// PURPOSE
//  Parametrised successor to the single-key scale selector. Two active-low keys step
//  the piano octave/scale up or down, with per-key debounce and hold-to-repeat. Both
//  keys together form a "home" gesture that reloads RESET_SCALE. Wrap or saturate at
//  the limits is selectable, and LED display mode is selectable. Output feeds the
//  note-frequency lookup and the board LEDs.
// PARAMETERS
//  SAMPLE_COUNT     9375000  clk cycles per key-sample tick (>=2)
//  DEBOUNCE_SAMPLES 2        consecutive equal samples to change a debounced key state (1..15)
//  REPEAT_SAMPLES   8        ticks between auto-repeat steps while held; 0 = no repeat
//  SCALE_W          8        width of scale output
//  MIN_SCALE        1        lowest scale value
//  MAX_SCALE        5        highest scale value (< 2**SCALE_W)
//  RESET_SCALE      1        value after reset/home (MIN_SCALE..MAX_SCALE)
//  WRAP             1        1: MAX+1->MIN, MIN-1->MAX; 0: saturate at limits
//  LED_MODE         0        0: led = scale[7:0] binary; 1: thermometer, (scale-MIN_SCALE+1) LSBs set
// PORTS
//  clk         in   1        system clock
//  reset_n     in   1        asynchronous active-low reset
//  key_up_n    in   1        up key, 0 = pressed, already synchronised
//  key_dn_n    in   1        down key, 0 = pressed, already synchronised
//  scale       out  SCALE_W  current scale, registered
//  led         out  8        LED image of scale per LED_MODE, registered
//  step_pulse  out  1        1-cycle strobe when scale takes a new value
//  at_limit    out  1        1 when scale==MIN_SCALE or scale==MAX_SCALE
// BEHAVIOUR
//  Reset (async, immediate):
//   - scale=RESET_SCALE; led=image(RESET_SCALE); step_pulse=0; at_limit from RESET_SCALE.
//   - Tick counter, debounce counters and repeat counter = 0. Debounced keys = released. FSM = IDLE.
//  Tick generation:
//   - Counter runs 0..SAMPLE_COUNT-1 and wraps.
//   - tick=1 for one cycle when counter==SAMPLE_COUNT-1.
//  Debounce (per key, on tick only):
//   - Sample differs from debounced state: increment that key's counter.
//     On reaching DEBOUNCE_SAMPLES, flip the debounced state and clear the counter.
//   - Sample equals debounced state: clear the counter.
//  FSM (evaluated in the cycle after a tick; "up"/"dn" = debounced pressed):
//   - IDLE:
//       up & !dn: step +1, -> UP_HOLD.
//       dn & !up: step -1, -> DN_HOLD.
//       up & dn: home, -> BOTH.
//   - UP_HOLD / DN_HOLD:
//       Other key pressed: home, -> BOTH.
//       Own key released: -> IDLE, no step. A key still held is treated as a new press
//         at the next evaluation.
//       Otherwise repeat counter +1. At REPEAT_SAMPLES: step again, clear counter.
//         REPEAT_SAMPLES=0 never repeats.
//   - BOTH: no steps. -> IDLE only when both keys are released.
//   - Repeat counter clears on every state entry.
//  Step arithmetic:
//   - +1 at MAX_SCALE: WRAP ? MIN_SCALE : hold. -1 at MIN_SCALE: WRAP ? MAX_SCALE : hold.
//   - Compute in SCALE_W+1 bits so there is no silent overflow.
//  Home: load RESET_SCALE.
//  Output timing:
//   - scale, led, at_limit and step_pulse update on the same edge, 2 cycles after the tick edge.
//   - step_pulse=1 for exactly that cycle, only if the new value != the old value.
//     A saturated hold gives no pulse; a home at RESET_SCALE gives no pulse.
//  Latency:
//   - Press to first step: DEBOUNCE_SAMPLES ticks + 2 cycles.
//   - Held key steps every REPEAT_SAMPLES ticks after that.
//  Elaboration asserts: MIN<=RESET<=MAX; LED_MODE=1 requires MAX-MIN+1<=8.
// TESTING (SAMPLE_COUNT=4, DEBOUNCE_SAMPLES=2, REPEAT_SAMPLES=3, MIN=1, MAX=5, RESET=1)
//  1 Reset, LED_MODE=1 -> scale=1, led=8'b0000_0001, at_limit=1, step_pulse=0.
//  2 key_up_n low 1 tick then high -> no change. Low 2 ticks -> scale=2, one step_pulse, led=8'b11.
//  3 WRAP=1, up held 15 ticks -> scale 2,3,4,5,1 (first step at debounce, then every 3 ticks),
//    one pulse each.
//  4 WRAP=0, scale=5, press up -> scale stays 5, no step_pulse, at_limit=1. Same for down at 1.
//  5 scale=4, hold up then press down -> scale=1 (home), then no steps until both released.
//    Releasing one key alone does nothing.
//  6 Assert reset_n low mid-hold at scale=3 -> outputs reset asynchronously.
//    Key held through reset: one step after the debounce period, never an immediate step.

Source files
------------

// File: rtl/octave_selector_if.sv
// Key inputs and scale/LED outputs of the octave selector, bundled for the board top.
interface octave_selector_if #(
    parameter int SCALE_W = 8
);
    logic               key_up_n;
    logic               key_dn_n;
    logic [SCALE_W-1:0] scale;
    logic [7:0]         led;
    logic               step_pulse;
    logic               at_limit;

    modport master (
        output key_up_n, key_dn_n,
        input  scale, led, step_pulse, at_limit
    );

    modport slave (
        input  key_up_n, key_dn_n,
        output scale, led, step_pulse, at_limit
    );
endinterface

// File: rtl/octave_selector.sv
// Two-key octave/scale selector with debounce, hold-to-repeat and a both-keys "home" gesture.
// Output pipeline: tick edge -> FSM decision edge -> scale/led/strobe edge.
module octave_selector #(
    parameter int SAMPLE_COUNT     = 9375000,
    parameter int DEBOUNCE_SAMPLES = 2,
    parameter int REPEAT_SAMPLES   = 8,
    parameter int SCALE_W          = 8,
    parameter int MIN_SCALE        = 1,
    parameter int MAX_SCALE        = 5,
    parameter int RESET_SCALE      = 1,
    parameter int WRAP             = 1,
    parameter int LED_MODE         = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    octave_selector_if.slave  bus
);
    localparam int TW  = (SAMPLE_COUNT > 1) ? $clog2(SAMPLE_COUNT) : 1;
    localparam int RW  = $clog2(REPEAT_SAMPLES + 2);
    localparam int SW1 = SCALE_W + 1;

    if (RESET_SCALE < MIN_SCALE || RESET_SCALE > MAX_SCALE || MIN_SCALE > MAX_SCALE) begin : g_bad_reset
        $error("RESET_SCALE must lie within MIN_SCALE..MAX_SCALE");
    end
    if (LED_MODE == 1 && (MAX_SCALE - MIN_SCALE + 1) > 8) begin : g_bad_led
        $error("thermometer LED mode needs MAX_SCALE-MIN_SCALE+1 <= 8");
    end
    if (SAMPLE_COUNT < 2 || DEBOUNCE_SAMPLES < 1 || DEBOUNCE_SAMPLES > 15 ||
        MAX_SCALE >= (1 << SCALE_W)) begin : g_bad_range
        $error("SAMPLE_COUNT, DEBOUNCE_SAMPLES or MAX_SCALE out of range");
    end

    typedef enum logic [1:0] {IDLE, UP_HOLD, DN_HOLD, BOTH} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_UP, CMD_DN, CMD_HOME} cmd_t;

    function automatic logic [7:0] led_image(input logic [SCALE_W-1:0] v);
        logic [7:0] img;
        img = 8'(v);
        if (LED_MODE == 1) begin
            for (int i = 0; i < 8; i++) img[i] = ({1'b0, v} >= SW1'(MIN_SCALE + i));
        end
        return img;
    endfunction

    function automatic logic is_limit(input logic [SCALE_W-1:0] v);
        return (v == SCALE_W'(MIN_SCALE)) || (v == SCALE_W'(MAX_SCALE));
    endfunction

    // Sample tick
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          tick_d;

    assign tick = (tick_cnt == TW'(SAMPLE_COUNT - 1));

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            tick_d   <= 1'b0;
        end else begin
            tick_d   <= tick;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    // Debounce, index 0 = up, 1 = down; 1 means pressed
    logic [1:0] raw;
    logic [1:0] db;
    logic [3:0] db_cnt [2];

    assign raw = {~bus.key_dn_n, ~bus.key_up_n};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db <= 2'b00;
            // NOTE: this small counter array is reset explicitly; it is control state, not storage.
            for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
        end else if (tick) begin
            for (int k = 0; k < 2; k++) begin
                if (raw[k] != db[k]) begin
                    if (db_cnt[k] == 4'(DEBOUNCE_SAMPLES - 1)) begin
                        db[k]     <= raw[k];
                        db_cnt[k] <= '0;
                    end else begin
                        db_cnt[k] <= db_cnt[k] + 1'b1;
                    end
                end else begin
                    db_cnt[k] <= '0;
                end
            end
        end
    end

    // Key FSM: decides once per tick, in the cycle after the debounced state settles
    state_t        state;
    cmd_t          cmd;
    logic [RW-1:0] rep_cnt;
    logic          up;
    logic          dn;

    assign up = db[0];
    assign dn = db[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cmd     <= CMD_NONE;
            rep_cnt <= '0;
        end else begin
            cmd <= CMD_NONE;
            if (tick_d) begin
                case (state)
                    IDLE: begin
                        rep_cnt <= '0;
                        if (up && dn) begin
                            cmd   <= CMD_HOME;
                            state <= BOTH;
                        end else if (up) begin
                            cmd   <= CMD_UP;
                            state <= UP_HOLD;
                        end else if (dn) begin
                            cmd   <= CMD_DN;
                            state <= DN_HOLD;
                        end
                    end
                    UP_HOLD, DN_HOLD: begin
                        if ((state == UP_HOLD) ? dn : up) begin
                            cmd     <= CMD_HOME;
                            state   <= BOTH;
                            rep_cnt <= '0;
                        end else if (!((state == UP_HOLD) ? up : dn)) begin
                            state   <= IDLE;
                            rep_cnt <= '0;
                        end else if (REPEAT_SAMPLES != 0) begin
                            if (rep_cnt == RW'(REPEAT_SAMPLES - 1)) begin
                                cmd     <= (state == UP_HOLD) ? CMD_UP : CMD_DN;
                                rep_cnt <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (!up && !dn) begin
                            state   <= IDLE;
                            rep_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

    // Step arithmetic, one bit wider than the scale so +1 at the top cannot overflow
    logic [SCALE_W-1:0] scale_q;
    logic [SCALE_W-1:0] next_scale;
    logic [SW1-1:0]     wide;
    logic [7:0]         led_q;
    logic               pulse_q;
    logic               limit_q;

    // NOTE: defaults first so no path through the case leaves next_scale unassigned (no latch).
    always_comb begin
        wide       = {1'b0, scale_q};
        next_scale = scale_q;
        case (cmd)
            CMD_UP:   if (wide >= SW1'(MAX_SCALE)) next_scale = (WRAP != 0) ? SCALE_W'(MIN_SCALE) : scale_q;
                      else                         next_scale = SCALE_W'(wide + 1'b1);
            CMD_DN:   if (wide <= SW1'(MIN_SCALE)) next_scale = (WRAP != 0) ? SCALE_W'(MAX_SCALE) : scale_q;
                      else                         next_scale = SCALE_W'(wide - 1'b1);
            CMD_HOME: next_scale = SCALE_W'(RESET_SCALE);
            default:  next_scale = scale_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scale_q <= SCALE_W'(RESET_SCALE);
            led_q   <= led_image(SCALE_W'(RESET_SCALE));
            limit_q <= is_limit(SCALE_W'(RESET_SCALE));
            pulse_q <= 1'b0;
        end else begin
            scale_q <= next_scale;
            led_q   <= led_image(next_scale);
            limit_q <= is_limit(next_scale);
            pulse_q <= (next_scale != scale_q);
        end
    end

    assign bus.scale      = scale_q;
    assign bus.led        = led_q;
    assign bus.step_pulse = pulse_q;
    assign bus.at_limit   = limit_q;
endmodule
